// File: rtl/pipe_stage_chain_pkg.sv
// Shared types and helpers for the elastic pipeline-register chain.
package pipe_stage_chain_pkg;

  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic [1:0] {
    STG_ADVANCE = 2'd0,
    STG_HOLD    = 2'd1,
    STG_BUBBLE  = 2'd2,
    STG_FLUSH   = 2'd3
  } stage_ctl_e;

  function automatic int occ_width(input int stages);
    return $clog2(stages + 1);
  endfunction

  function automatic int popcount(input logic [63:0] bits);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) n += int'(bits[i]);
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Valid/ready stream bundle used on both faces of the pipeline chain.
interface pipe_stage_chain_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_chain_stage.sv
// One pipeline register: a valid bit plus DATA_W payload, steered by a per-stage control code.
module pipe_stage_chain_stage
  import pipe_stage_chain_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  stage_ctl_e        ctl,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // Payload only moves with a valid word so bubbles leave the old data untouched.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      unique case (ctl)
        STG_FLUSH:   valid <= 1'b0;
        STG_BUBBLE:  valid <= 1'b0;
        STG_ADVANCE: begin
          valid <= src_valid;
          if (src_valid) data <= src_data;
        end
        STG_HOLD:    begin end
      endcase
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic pipeline-register chain with backpressure, hazard hold with bubble
// insertion, per-stage flush and saturating stall/flush counters.
module pipe_stage_chain
  import pipe_stage_chain_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int STAGES     = 4,
  parameter int HOLD_STAGE = 1,
  parameter int CNT_W      = DEFAULT_CNT_W
) (
  input  logic                          clk,
  input  logic                          reset,
  pipe_stage_chain_if.slave             up,
  pipe_stage_chain_if.master            dn,
  input  logic                          hold,
  input  logic [STAGES-1:0]             flush,
  output logic [STAGES-1:0]             stage_valid,
  output logic [occ_width(STAGES)-1:0]  occupancy,
  output logic [CNT_W-1:0]              stall_cnt,
  output logic [CNT_W-1:0]              flush_cnt
);

  localparam int OCC_W = occ_width(STAGES);
  localparam int SUM_W = CNT_W + OCC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (STAGES < 2) begin : g_bad_stages
    $error("pipe_stage_chain: STAGES must be at least 2");
  end
  if (HOLD_STAGE < 0 || HOLD_STAGE >= STAGES - 1) begin : g_bad_hold
    $error("pipe_stage_chain: HOLD_STAGE must lie in 0..STAGES-2");
  end

  logic [STAGES-1:0] stage_v;
  logic [DATA_W-1:0] stage_d   [STAGES];
  logic [STAGES-1:0] src_valid;
  logic [DATA_W-1:0] src_data  [STAGES];
  logic [STAGES-1:0] rdy;
  stage_ctl_e        ctl       [STAGES];
  logic [OCC_W-1:0]  flush_hits;
  logic [SUM_W-1:0]  flush_sum;

  // A stage is ready when it or any stage downstream of it has a free slot.
  always_comb begin
    logic acc;
    acc = dn.ready;
    rdy = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc    = acc | !stage_v[i];
      rdy[i] = acc;
    end
  end

  // A flushed stage presents a bubble to its successor.
  always_comb begin
    src_valid    = '0;
    src_valid[0] = up.valid;
    src_data[0]  = up.data;
    for (int i = 1; i < STAGES; i++) begin
      src_valid[i] = stage_v[i-1] & !flush[i-1];
      src_data[i]  = stage_d[i-1];
    end
  end

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      ctl[i] = STG_HOLD;
      if (flush[i])
        ctl[i] = STG_FLUSH;
      else if (hold && i <= HOLD_STAGE)
        ctl[i] = STG_HOLD;
      else if (hold && i == HOLD_STAGE + 1)
        ctl[i] = rdy[i] ? STG_BUBBLE : STG_HOLD;
      else
        ctl[i] = rdy[i] ? STG_ADVANCE : STG_HOLD;
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    pipe_stage_chain_stage #(
      .DATA_W (DATA_W)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .ctl       (ctl[g]),
      .src_valid (src_valid[g]),
      .src_data  (src_data[g]),
      .valid     (stage_v[g]),
      .data      (stage_d[g])
    );
  end

  assign up.ready    = rdy[0] & !hold & reset;
  assign dn.valid    = stage_v[STAGES-1];
  assign dn.data     = stage_d[STAGES-1];
  assign stage_valid = stage_v;
  assign occupancy   = OCC_W'(popcount(64'(stage_v)));
  assign flush_hits  = OCC_W'(popcount(64'(flush & stage_v)));
  assign flush_sum   = SUM_W'(flush_cnt) + SUM_W'(flush_hits);

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hold && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
      flush_cnt <= (flush_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : flush_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed self-checking bench: table-driven streaming/backpressure vectors plus
// hand-written hold, flush, reset and counter-saturation sequences.
module tb_pipe_stage_chain;
  import pipe_stage_chain_pkg::*;

  localparam int DATA_W     = 32;
  localparam int STAGES     = 4;
  localparam int HOLD_STAGE = 1;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        exp_ir;
    logic        exp_ov;
    logic [31:0] exp_od;
    logic [3:0]  exp_sv;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        hold = 1'b0;
  logic [3:0]  flush = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic [3:0]  stage_valid, stage_valid_s;
  logic [2:0]  occupancy, occupancy_s;
  logic [15:0] stall_cnt, flush_cnt;
  logic [3:0]  stall_cnt_s, flush_cnt_s;

  int passed = 0;
  int total  = 0;
  vec_t vecs[$];
  logic [31:0] exp_q[$];

  pipe_stage_chain_if #(.DATA_W(DATA_W)) up_if ();
  pipe_stage_chain_if #(.DATA_W(DATA_W)) dn_if ();
  pipe_stage_chain_if #(.DATA_W(DATA_W)) up_s ();
  pipe_stage_chain_if #(.DATA_W(DATA_W)) dn_s ();

  assign up_if.valid = in_valid;
  assign up_if.data  = in_data;
  assign dn_if.ready = out_ready;
  assign up_s.valid  = in_valid;
  assign up_s.data   = in_data;
  assign dn_s.ready  = out_ready;

  pipe_stage_chain #(
    .DATA_W(DATA_W), .STAGES(STAGES), .HOLD_STAGE(HOLD_STAGE), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .up(up_if), .dn(dn_if), .hold(hold), .flush(flush),
    .stage_valid(stage_valid), .occupancy(occupancy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_chain #(
    .DATA_W(DATA_W), .STAGES(STAGES), .HOLD_STAGE(HOLD_STAGE), .CNT_W(4)
  ) dut_small (
    .clk(clk), .reset(reset), .up(up_s), .dn(dn_s), .hold(hold), .flush(flush),
    .stage_valid(stage_valid_s), .occupancy(occupancy_s),
    .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic iv, input logic [31:0] d, input logic ordy,
                               input logic hd, input logic [3:0] fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    hold      = hd;
    flush     = fl;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    else
      passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic iv, input logic [31:0] id, input logic ordy,
                              input logic ir, input logic ov, input logic [31:0] od,
                              input logic [3:0] sv);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy;
    v.exp_ir = ir; v.exp_ov = ov; v.exp_od = od; v.exp_sv = sv;
    return v;
  endfunction

  // Loads four consecutive words into an empty chain while the output is blocked.
  task automatic fill(input logic [31:0] base);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, base + 32'(k), 1'b0, 1'b0, 4'b0000);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'b0000);
    checkOutput("fill stage_valid", 64'(stage_valid), 64'hF);
  endtask

  // Drains with out_ready high and compares the emitted words against exp_q.
  task automatic drainExpect(input string name);
    int got;
    got = 0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'b0000);
    for (int c = 0; c < 12 && got < exp_q.size(); c++) begin
      if (dn_if.valid) begin
        checkOutput($sformatf("%s word%0d", name, got), 64'(dn_if.data), 64'(exp_q[got]));
        got++;
      end
      tick();
    end
    checkOutput($sformatf("%s count", name), 64'(got), 64'(exp_q.size()));
    checkOutput($sformatf("%s empty", name), 64'(stage_valid), 64'h0);
  endtask

  initial begin
    // Reset
    applyStimulus(1'b1, 32'hDEAD, 1'b1, 1'b0, 4'b0000);
    reset = 1'b0;
    #1;
    checkOutput("reset in_ready", 64'(up_if.ready), 64'h0);
    tick();
    tick();
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'b0000);
    checkOutput("reset out_valid", 64'(dn_if.valid), 64'h0);
    checkOutput("reset occupancy", 64'(occupancy), 64'h0);
    checkOutput("reset stall_cnt", 64'(stall_cnt), 64'h0);
    checkOutput("reset flush_cnt", 64'(flush_cnt), 64'h0);
    checkOutput("reset small state",
                64'({stage_valid_s, occupancy_s, stall_cnt_s, flush_cnt_s, dn_s.valid}), 64'h0);
    checkOutput("reset out_data", 64'(dn_if.data), 64'h0);

    // Streaming at full rate, then draining
    vecs.push_back(mk(1, 32'h100, 1, 1, 0, 32'h0,   4'b0000));
    vecs.push_back(mk(1, 32'h101, 1, 1, 0, 32'h0,   4'b0001));
    vecs.push_back(mk(1, 32'h102, 1, 1, 0, 32'h0,   4'b0011));
    vecs.push_back(mk(1, 32'h103, 1, 1, 0, 32'h0,   4'b0111));
    vecs.push_back(mk(1, 32'h104, 1, 1, 1, 32'h100, 4'b1111));
    vecs.push_back(mk(1, 32'h105, 1, 1, 1, 32'h101, 4'b1111));
    vecs.push_back(mk(1, 32'h106, 1, 1, 1, 32'h102, 4'b1111));
    vecs.push_back(mk(1, 32'h107, 1, 1, 1, 32'h103, 4'b1111));
    vecs.push_back(mk(0, 32'h0,   1, 1, 1, 32'h104, 4'b1111));
    vecs.push_back(mk(0, 32'h0,   1, 1, 1, 32'h105, 4'b1110));
    vecs.push_back(mk(0, 32'h0,   1, 1, 1, 32'h106, 4'b1100));
    vecs.push_back(mk(0, 32'h0,   1, 1, 1, 32'h107, 4'b1000));
    vecs.push_back(mk(0, 32'h0,   1, 1, 0, 32'h0,   4'b0000));
    // Backpressure: fill, stall input, release and drain
    vecs.push_back(mk(1, 32'h200, 0, 1, 0, 32'h0,   4'b0000));
    vecs.push_back(mk(1, 32'h201, 0, 1, 0, 32'h0,   4'b0001));
    vecs.push_back(mk(1, 32'h202, 0, 1, 0, 32'h0,   4'b0011));
    vecs.push_back(mk(1, 32'h203, 0, 1, 0, 32'h0,   4'b0111));
    vecs.push_back(mk(1, 32'h204, 0, 0, 1, 32'h200, 4'b1111));
    vecs.push_back(mk(1, 32'h204, 0, 0, 1, 32'h200, 4'b1111));
    vecs.push_back(mk(1, 32'h204, 1, 1, 1, 32'h200, 4'b1111));
    vecs.push_back(mk(0, 32'h0,   1, 1, 1, 32'h201, 4'b1111));
    vecs.push_back(mk(0, 32'h0,   1, 1, 1, 32'h202, 4'b1110));
    vecs.push_back(mk(0, 32'h0,   1, 1, 1, 32'h203, 4'b1100));
    vecs.push_back(mk(0, 32'h0,   1, 1, 1, 32'h204, 4'b1000));
    vecs.push_back(mk(0, 32'h0,   1, 1, 0, 32'h0,   4'b0000));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].iv, vecs[i].id, vecs[i].ordy, 1'b0, 4'b0000);
      #1;
      checkOutput($sformatf("v%0d in_ready", i), 64'(up_if.ready), 64'(vecs[i].exp_ir));
      checkOutput($sformatf("v%0d out_valid", i), 64'(dn_if.valid), 64'(vecs[i].exp_ov));
      if (vecs[i].exp_ov)
        checkOutput($sformatf("v%0d out_data", i), 64'(dn_if.data), 64'(vecs[i].exp_od));
      checkOutput($sformatf("v%0d stage_valid", i), 64'(stage_valid), 64'(vecs[i].exp_sv));
      checkOutput($sformatf("v%0d occupancy", i), 64'(occupancy), 64'($countones(vecs[i].exp_sv)));
      tick();
    end

    // Hold for one cycle: lower stages frozen, bubble into stage 2
    fill(32'h300);
    applyStimulus(1'b1, 32'h304, 1'b1, 1'b1, 4'b0000);
    #1;
    checkOutput("hold in_ready", 64'(up_if.ready), 64'h0);
    checkOutput("hold out_data", 64'(dn_if.data), 64'h300);
    tick();
    checkOutput("hold stage_valid", 64'(stage_valid), 64'hB);
    checkOutput("hold out_data next", 64'(dn_if.data), 64'h301);
    checkOutput("hold stall_cnt", 64'(stall_cnt), 64'd1);
    applyStimulus(1'b1, 32'h304, 1'b1, 1'b0, 4'b0000);
    #1;
    checkOutput("resume in_ready", 64'(up_if.ready), 64'h1);
    tick();
    checkOutput("resume stage_valid", 64'(stage_valid), 64'h7);
    exp_q.delete();
    exp_q.push_back(32'h302); exp_q.push_back(32'h303); exp_q.push_back(32'h304);
    drainExpect("hold drain");

    // Flush the two youngest stages
    fill(32'h400);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'b0011);
    #1;
    checkOutput("flush out_data", 64'(dn_if.data), 64'h400);
    tick();
    checkOutput("flush stage_valid", 64'(stage_valid), 64'h8);
    checkOutput("flush flush_cnt", 64'(flush_cnt), 64'd2);
    checkOutput("flush out_data next", 64'(dn_if.data), 64'h401);
    exp_q.delete();
    exp_q.push_back(32'h401);
    drainExpect("flush drain");

    // Hold and flush of stage 1 together
    fill(32'h500);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'b0010);
    tick();
    checkOutput("hold+flush stage_valid", 64'(stage_valid), 64'h9);
    checkOutput("hold+flush stall_cnt", 64'(stall_cnt), 64'd2);
    checkOutput("hold+flush flush_cnt", 64'(flush_cnt), 64'd3);
    exp_q.delete();
    exp_q.push_back(32'h501); exp_q.push_back(32'h503);
    drainExpect("hold+flush drain");

    // Hold under full backpressure: no bubble may be created
    fill(32'h600);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 4'b0000);
    tick();
    checkOutput("hold+bp stage_valid", 64'(stage_valid), 64'hF);
    checkOutput("hold+bp out_data", 64'(dn_if.data), 64'h600);
    checkOutput("hold+bp stall_cnt", 64'(stall_cnt), 64'd3);
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(32'h600 + 32'(k));
    drainExpect("hold+bp drain");

    // Reset mid-stream, then saturate the narrow stall counter
    applyStimulus(1'b1, 32'h700, 1'b1, 1'b0, 4'b0000);
    tick();
    applyStimulus(1'b1, 32'h701, 1'b1, 1'b0, 4'b0000);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("midreset in_ready", 64'(up_if.ready), 64'h0);
    tick();
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'b0000);
    checkOutput("midreset stage_valid", 64'(stage_valid), 64'h0);
    checkOutput("midreset occupancy", 64'(occupancy), 64'h0);
    checkOutput("midreset stall_cnt", 64'(stall_cnt), 64'h0);
    checkOutput("midreset flush_cnt", 64'(flush_cnt), 64'h0);
    checkOutput("midreset small stall_cnt", 64'(stall_cnt_s), 64'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'b0000);
    repeat (20) tick();
    checkOutput("sat stall_cnt wide", 64'(stall_cnt), 64'd20);
    checkOutput("sat stall_cnt narrow", 64'(stall_cnt_s), 64'd15);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'b0000);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
